// File: rtl/lcd_seq_ctrl.sv
// ----------------------------------------------------------------------------
// lcd_seq_ctrl
//
// Sequencing controller for an HD44780-compatible character LCD driven in
// write-only 8-bit mode.
//
// Power-up behaviour:
//   - After reset it waits PWRUP_CYC clocks.
//   - It then issues the init commands 0x38, 0x0C, 0x01 and 0x06.
//   - It then accepts payload bytes over a valid/ready handshake.
//
// Byte mapping:
//   - 0x0C clears the display.
//   - 0x0D returns to column 0 of the current line.
//   - 0x0A toggles the line and returns to column 0.
//   - Every other value becomes a data write.
//
// Timing: the busy flag is never read. Every write cycle is
// SETUP (1) -> EN_HI (EN_CYC) -> HOLD (1) -> WAIT (CMD_CYC or CLR_CYC).
//
// Build option:
//   LCD_AUTOWRAP_EN
//     Defined: the printable byte that follows a write to the last visible
//     column first moves the cursor to the other line's DDRAM base, using a
//     chained command write.
//     Undefined: the column saturates and no automatic cursor command is sent.
//
// Ports:
//   CLK_I       system clock
//   RST_I       asynchronous active-high reset
//   DATA_I      byte to display or control code
//   VLD_I       DATA_I valid (transfer on VLD_I & RDY_O)
//   RDY_O       high only while idle and able to accept a byte
//   BUSY_O      inverse of RDY_O
//   LCD_RW_O    read/write select, always 0 (write-only)
//   LCD_RS_O    0 = command, 1 = data
//   LCD_EN_O    enable strobe
//   LCD_DATA_O  LCD data bus
// ----------------------------------------------------------------------------
module lcd_seq_ctrl #(
    parameter int CLK_HZ     = 27_000_000,
    parameter int LCD_DATA_W = 8,
    parameter int COLS       = 16,
    parameter int EN_CYC     = 12,
    parameter int CMD_CYC    = int'((64'(CLK_HZ) * 64'd40) / 64'd1_000_000),
    parameter int CLR_CYC    = int'((64'(CLK_HZ) * 64'd1640) / 64'd1_000_000),
    parameter int PWRUP_CYC  = int'((64'(CLK_HZ) * 64'd15) / 64'd1000)
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic [LCD_DATA_W-1:0] DATA_I,
    input  logic                  VLD_I,
    output logic                  RDY_O,
    output logic                  BUSY_O,
    output logic                  LCD_RW_O,
    output logic                  LCD_RS_O,
    output logic                  LCD_EN_O,
    output logic [LCD_DATA_W-1:0] LCD_DATA_O
);

    // ------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int MAX_AB  = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
    localparam int MAX_CD  = (CMD_CYC > EN_CYC) ? CMD_CYC : EN_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Each timed state ends when the counter reaches its duration minus one.
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_CYC - 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    localparam logic [LCD_DATA_W-1:0] CH_FF     = LCD_DATA_W'(8'h0C);
    localparam logic [LCD_DATA_W-1:0] CH_CR     = LCD_DATA_W'(8'h0D);
    localparam logic [LCD_DATA_W-1:0] CH_LF     = LCD_DATA_W'(8'h0A);
    localparam logic [LCD_DATA_W-1:0] CMD_CLEAR = LCD_DATA_W'(8'h01);
    localparam logic [LCD_DATA_W-1:0] CMD_LINE0 = LCD_DATA_W'(8'h80);
    localparam logic [LCD_DATA_W-1:0] CMD_LINE1 = LCD_DATA_W'(8'hC0);

    localparam int INIT_LEN = 4;

    // Init commands: 8-bit/2-line, display on, clear, entry increment.
    // Entry 0 sits in the least significant byte.
    localparam logic [INIT_LEN*LCD_DATA_W-1:0] INIT_SEQ = {
        LCD_DATA_W'(8'h06), LCD_DATA_W'(8'h01),
        LCD_DATA_W'(8'h0C), LCD_DATA_W'(8'h38)
    };

    typedef enum logic [2:0] {
        PWRUP, INIT, IDLE, SETUP, EN_HI, HOLD, WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Init command table
    // ------------------------------------------------------------------
    logic [LCD_DATA_W-1:0] init_rom [INIT_LEN];

    genvar gi;
    generate
        for (gi = 0; gi < INIT_LEN; gi++) begin : g_init_rom
            assign init_rom[gi] = INIT_SEQ[gi*LCD_DATA_W +: LCD_DATA_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [COL_W-1:0]      col_reg, col_next;
    logic                  line_reg, line_next;

    // Set after a write to the last visible column.
    // Only ever set when autowrap is built in.
    logic                  wrap_reg, wrap_next;

    // Data write queued behind a cursor command.
    logic                  pend_vld_reg, pend_vld_next;
    logic [LCD_DATA_W-1:0] pend_data_reg, pend_data_next;

    logic [2:0]            init_idx_reg, init_idx_next;
    logic                  init_act_reg, init_act_next;
    logic                  lcd_rs_reg, lcd_rs_next;
    logic [LCD_DATA_W-1:0] lcd_data_reg, lcd_data_next;
    logic                  lcd_en_reg, lcd_en_next;
    logic                  rdy_reg, rdy_next;
    logic                  busy_reg, busy_next;

    logic [CNT_W-1:0]      wait_last;

    // The word on the bus during WAIT is the one just written.
    // It therefore selects the post-write delay.
    assign wait_last = (!lcd_rs_reg && lcd_data_reg == CMD_CLEAR) ? CLR_LAST : CMD_LAST;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_reg     <= PWRUP;
            cnt_reg       <= '0;
            col_reg       <= '0;
            line_reg      <= 1'b0;
            wrap_reg      <= 1'b0;
            pend_vld_reg  <= 1'b0;
            pend_data_reg <= '0;
            init_idx_reg  <= '0;
            init_act_reg  <= 1'b1;
            lcd_rs_reg    <= 1'b0;
            lcd_data_reg  <= '0;
            lcd_en_reg    <= 1'b0;
            rdy_reg       <= 1'b0;
            busy_reg      <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            col_reg       <= col_next;
            line_reg      <= line_next;
            wrap_reg      <= wrap_next;
            pend_vld_reg  <= pend_vld_next;
            pend_data_reg <= pend_data_next;
            init_idx_reg  <= init_idx_next;
            init_act_reg  <= init_act_next;
            lcd_rs_reg    <= lcd_rs_next;
            lcd_data_reg  <= lcd_data_next;
            lcd_en_reg    <= lcd_en_next;
            rdy_reg       <= rdy_next;
            busy_reg      <= busy_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            PWRUP: if (cnt_reg == PWRUP_LAST) state_next = INIT;
            INIT:  state_next = (init_idx_reg < 3'(INIT_LEN)) ? SETUP : IDLE;
            IDLE:  if (VLD_I) state_next = SETUP;
            SETUP: state_next = EN_HI;
            EN_HI: if (cnt_reg == EN_LAST) state_next = HOLD;
            HOLD:  state_next = WAIT;
            WAIT: begin
                if (cnt_reg == wait_last) begin
                    if (init_act_reg)      state_next = INIT;
                    else if (pend_vld_reg) state_next = SETUP;
                    else                   state_next = IDLE;
                end
            end
            default: state_next = PWRUP;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic
    // All outputs are registered, so they are computed from state_next.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_next       = cnt_reg;
        col_next       = col_reg;
        line_next      = line_reg;
        wrap_next      = wrap_reg;
        pend_vld_next  = pend_vld_reg;
        pend_data_next = pend_data_reg;
        init_idx_next  = init_idx_reg;
        init_act_next  = init_act_reg;
        lcd_rs_next    = lcd_rs_reg;
        lcd_data_next  = lcd_data_reg;

        lcd_en_next = (state_next == EN_HI);
        rdy_next    = (state_next == IDLE);
        busy_next   = (state_next != IDLE);

        if (state_next != state_reg || state_reg == IDLE) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end

        case (state_reg)
            INIT: begin
                if (init_idx_reg < 3'(INIT_LEN)) begin
                    lcd_rs_next   = 1'b0;
                    lcd_data_next = init_rom[init_idx_reg[1:0]];
                    init_idx_next = init_idx_reg + 3'd1;
                end else begin
                    init_act_next = 1'b0;
                    col_next      = '0;
                    line_next     = 1'b0;
                    wrap_next     = 1'b0;
                end
            end

            IDLE: begin
                if (VLD_I) begin
                    case (DATA_I)
                        CH_FF: begin
                            lcd_rs_next   = 1'b0;
                            lcd_data_next = CMD_CLEAR;
                            col_next      = '0;
                            line_next     = 1'b0;
                            wrap_next     = 1'b0;
                        end
                        CH_CR: begin
                            lcd_rs_next   = 1'b0;
                            lcd_data_next = line_reg ? CMD_LINE1 : CMD_LINE0;
                            col_next      = '0;
                            wrap_next     = 1'b0;
                        end
                        CH_LF: begin
                            // Base address of the line being moved to.
                            lcd_rs_next   = 1'b0;
                            lcd_data_next = line_reg ? CMD_LINE0 : CMD_LINE1;
                            line_next     = ~line_reg;
                            col_next      = '0;
                            wrap_next     = 1'b0;
                        end
                        default: begin
`ifdef LCD_AUTOWRAP_EN
                            if (wrap_reg) begin
                                // Cursor command to the other line now.
                                // The byte itself follows as a chained
                                // data write at column 0.
                                lcd_rs_next    = 1'b0;
                                lcd_data_next  = line_reg ? CMD_LINE0 : CMD_LINE1;
                                line_next      = ~line_reg;
                                pend_vld_next  = 1'b1;
                                pend_data_next = DATA_I;
                                col_next       = (COLS > 1) ? COL_W'(1) : '0;
                                wrap_next      = (COLS == 1);
                            end else begin
                                lcd_rs_next   = 1'b1;
                                lcd_data_next = DATA_I;
                                if (col_reg == COL_LAST) begin
                                    col_next  = '0;
                                    wrap_next = 1'b1;
                                end else begin
                                    col_next = col_reg + COL_W'(1);
                                end
                            end
`else
                            lcd_rs_next   = 1'b1;
                            lcd_data_next = DATA_I;
                            if (col_reg != COL_LAST) begin
                                col_next = col_reg + COL_W'(1);
                            end
`endif
                        end
                    endcase
                end
            end

            WAIT: begin
                if (state_next == SETUP) begin
                    lcd_rs_next   = 1'b1;
                    lcd_data_next = pend_data_reg;
                    pend_vld_next = 1'b0;
                end
            end

            default: begin
            end
        endcase
    end

    assign RDY_O      = rdy_reg;
    assign BUSY_O     = busy_reg;
    assign LCD_RW_O   = 1'b0;
    assign LCD_RS_O   = lcd_rs_reg;
    assign LCD_EN_O   = lcd_en_reg;
    assign LCD_DATA_O = lcd_data_reg;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lcd_seq_ctrl
//
// Drives lcd_seq_ctrl with directed and random bytes. It checks every LCD
// write and every busy window against a cursor model kept in the bench.
// Outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_lcd_seq_ctrl;

    localparam int COLS      = 16;
    localparam int EN_CYC    = 2;
    localparam int CMD_CYC   = 5;
    localparam int CLR_CYC   = 20;
    localparam int PWRUP_CYC = 10;
    localparam int N_RAND    = 150;

`ifdef LCD_AUTOWRAP_EN
    localparam bit AUTOWRAP = 1'b1;
`else
    localparam bit AUTOWRAP = 1'b0;
`endif

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b1;
    logic [7:0] DATA_I = 8'h00;
    logic       VLD_I = 1'b0;
    logic       RDY_O, BUSY_O, LCD_RW_O, LCD_RS_O, LCD_EN_O;
    logic [7:0] LCD_DATA_O;

    lcd_seq_ctrl #(
        .CLK_HZ    (27_000_000),
        .LCD_DATA_W(8),
        .COLS      (COLS),
        .EN_CYC    (EN_CYC),
        .CMD_CYC   (CMD_CYC),
        .CLR_CYC   (CLR_CYC),
        .PWRUP_CYC (PWRUP_CYC)
    ) dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .DATA_I    (DATA_I),
        .VLD_I     (VLD_I),
        .RDY_O     (RDY_O),
        .BUSY_O    (BUSY_O),
        .LCD_RW_O  (LCD_RW_O),
        .LCD_RS_O  (LCD_RS_O),
        .LCD_EN_O  (LCD_EN_O),
        .LCD_DATA_O(LCD_DATA_O)
    );

    always #5 CLK_I = ~CLK_I;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model.
    // m_col is the column the next character lands in.
    //   - With autowrap it may equal COLS, meaning the line is full.
    //   - Without autowrap it saturates at COLS-1.
    // ------------------------------------------------------------------
    int         m_col, m_line;
    int         n_exp, exp_low;
    logic       exp_rs   [2];
    logic [7:0] exp_data [2];

    function automatic int post_wait(input logic rs, input logic [7:0] d);
        return (!rs && d == 8'h01) ? CLR_CYC : CMD_CYC;
    endfunction

    task automatic push_write(input logic rs, input logic [7:0] d);
        exp_rs[n_exp]   = rs;
        exp_data[n_exp] = d;
        n_exp++;
        exp_low += 2 + EN_CYC + post_wait(rs, d);
    endtask

    task automatic model_byte(input logic [7:0] b);
        n_exp   = 0;
        exp_low = 0;
        if (b == 8'h0C) begin
            push_write(1'b0, 8'h01);
            m_col  = 0;
            m_line = 0;
        end else if (b == 8'h0D) begin
            push_write(1'b0, (m_line == 1) ? 8'hC0 : 8'h80);
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_line = 1 - m_line;
            push_write(1'b0, (m_line == 1) ? 8'hC0 : 8'h80);
            m_col = 0;
        end else begin
            if (AUTOWRAP && m_col == COLS) begin
                m_line = 1 - m_line;
                push_write(1'b0, (m_line == 1) ? 8'hC0 : 8'h80);
                m_col = 0;
            end
            push_write(1'b1, b);
            m_col = m_col + 1;
            if (!AUTOWRAP && m_col > COLS - 1) m_col = COLS - 1;
        end
    endtask

    int         last_low, last_npul;
    logic [7:0] last_data0;

    // ------------------------------------------------------------------
    // Send one byte and observe the bus until RDY_O returns.
    // The task is entered on a falling edge.
    // If hold_next is set, VLD_I stays high with nb after acceptance.
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b, input bit hold_next, input logic [7:0] nb);
        int         guard, low, npul, width, unstable, side_bad;
        logic       prev_en, cap_rs;
        logic [7:0] cap_data;
        logic       got_rs   [4];
        logic [7:0] got_data [4];
        int         got_w    [4];

        guard = 0;
        while (RDY_O !== 1'b1 && guard < 200) begin
            @(negedge CLK_I);
            guard++;
        end
        check_val("rdy_before_send", RDY_O, 1);

        DATA_I = b;
        VLD_I  = 1'b1;
        model_byte(b);
        @(negedge CLK_I);
        if (hold_next) DATA_I = nb;
        else VLD_I = 1'b0;

        low = 0; npul = 0; width = 0; unstable = 0; side_bad = 0;
        prev_en = 1'b0; cap_rs = 1'b0; cap_data = 8'h00;
        while (RDY_O === 1'b0 && low < 200) begin
            low++;
            if (BUSY_O !== 1'b1 || LCD_RW_O !== 1'b0) side_bad++;
            if (LCD_EN_O === 1'b1 && !prev_en) begin
                cap_rs   = LCD_RS_O;
                cap_data = LCD_DATA_O;
                if (npul < 4) begin
                    got_rs[npul]   = cap_rs;
                    got_data[npul] = cap_data;
                end
                npul++;
                width = 0;
            end
            if (LCD_EN_O === 1'b1) begin
                width++;
                if (LCD_RS_O !== cap_rs || LCD_DATA_O !== cap_data) unstable++;
            end else if (prev_en) begin
                // Hold cycle: RS/DATA must still match the pulse.
                if (LCD_RS_O !== cap_rs || LCD_DATA_O !== cap_data) unstable++;
                if (npul <= 4) got_w[npul-1] = width;
            end
            prev_en = LCD_EN_O;
            @(negedge CLK_I);
        end

        check_val("busy_window", low, exp_low);
        check_val("pulse_count", npul, n_exp);
        for (int i = 0; i < n_exp && i < npul && i < 4; i++) begin
            check_val("write_rs", got_rs[i], exp_rs[i]);
            check_val("write_data", got_data[i], exp_data[i]);
            check_val("en_width", got_w[i], EN_CYC);
        end
        check_val("rs_data_stable", unstable, 0);
        check_val("busy_rw_while_low", side_bad, 0);
        check_val("busy_after", BUSY_O, 0);

        last_low   = low;
        last_npul  = npul;
        last_data0 = (npul > 0) ? got_data[0] : 8'hxx;
        $display("byte %02h: pulses=%0d busy_cycles=%0d col=%0d line=%0d", b, npul, low, m_col, m_line);
    endtask

    // ------------------------------------------------------------------
    // Observe the power-up wait and the four init commands.
    // The task is entered on the falling edge where reset was released.
    // ------------------------------------------------------------------
    task automatic check_init();
        logic [7:0] init_cmd [4];
        int         low, width, gap, w;

        init_cmd[0] = 8'h38;
        init_cmd[1] = 8'h0C;
        init_cmd[2] = 8'h01;
        init_cmd[3] = 8'h06;

        low = 0;
        while (LCD_EN_O !== 1'b1 && low < 100) begin
            low++;
            @(negedge CLK_I);
        end
        check_val("pwrup_at_least", (low >= PWRUP_CYC) ? 1 : 0, 1);
        check_val("pwrup_at_most", (low <= PWRUP_CYC + 4) ? 1 : 0, 1);

        for (int i = 0; i < 4; i++) begin
            check_val("init_rs", LCD_RS_O, 0);
            check_val("init_data", LCD_DATA_O, init_cmd[i]);
            width = 0;
            while (LCD_EN_O === 1'b1 && width < 50) begin
                width++;
                @(negedge CLK_I);
            end
            check_val("init_en_width", width, EN_CYC);

            gap = 0;
            while (LCD_EN_O === 1'b0 && RDY_O === 1'b0 && gap < 100) begin
                gap++;
                @(negedge CLK_I);
            end
            w = post_wait(1'b0, init_cmd[i]);
            if (i < 3) begin
                check_val("init_next_pulse", LCD_EN_O, 1);
                check_val("init_gap_min", (gap >= w + 2) ? 1 : 0, 1);
                check_val("init_gap_max", (gap <= w + 3) ? 1 : 0, 1);
            end else begin
                check_val("init_rdy_rise", RDY_O, 1);
                check_val("init_tail_min", (gap >= w + 1) ? 1 : 0, 1);
                check_val("init_tail_max", (gap <= w + 2) ? 1 : 0, 1);
            end
        end
        $display("init: pwrup_cycles=%0d", low);
    endtask

    logic [7:0] rnd_b    [N_RAND];
    bit         rnd_hold [N_RAND];

    initial begin
        int guard, r, rises;
        logic prev_en;

        m_col  = 0;
        m_line = 0;

        // Reset state.
        repeat (3) @(negedge CLK_I);
        check_val("rst_en", LCD_EN_O, 0);
        check_val("rst_rs", LCD_RS_O, 0);
        check_val("rst_rw", LCD_RW_O, 0);
        check_val("rst_data", LCD_DATA_O, 0);
        check_val("rst_rdy", RDY_O, 0);
        check_val("rst_busy", BUSY_O, 1);

        RST_I = 1'b0;
        check_init();

        // Single data byte: RDY_O low for 2+EN_CYC+CMD_CYC clocks.
        send_byte(8'h41, 1'b0, 8'h00);
        check_val("dir_41_low", last_low, 9);

        // Clear, then LF and CR on the new line.
        send_byte(8'h0C, 1'b0, 8'h00);
        check_val("dir_ff_low", last_low, 24);
        send_byte(8'h0A, 1'b0, 8'h00);
        check_val("dir_lf_cmd", last_data0, 8'hC0);
        send_byte(8'h0D, 1'b0, 8'h00);
        check_val("dir_cr_cmd", last_data0, 8'hC0);

        // Back to line 0 col 0, then fill one line plus one character.
        send_byte(8'h0C, 1'b0, 8'h00);
        for (int i = 0; i < 17; i++) send_byte(8'h30, 1'b0, 8'h00);
        check_val("dir_17th_pulses", last_npul, AUTOWRAP ? 2 : 1);
        check_val("dir_17th_first", last_data0, AUTOWRAP ? 8'hC0 : 8'h30);

        // VLD_I held high across busy windows.
        send_byte(8'h31, 1'b1, 8'h32);
        send_byte(8'h32, 1'b1, 8'h33);
        send_byte(8'h33, 1'b0, 8'h00);

        // Random traffic.
        for (int i = 0; i < N_RAND; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       rnd_b[i] = 8'h0A;
            else if (r < 16) rnd_b[i] = 8'h0D;
            else if (r < 20) rnd_b[i] = 8'h0C;
            else             rnd_b[i] = 8'($urandom_range(32, 126));
            rnd_hold[i] = ($urandom_range(0, 3) == 0);
        end
        for (int i = 0; i < N_RAND; i++) begin
            send_byte(rnd_b[i], rnd_hold[i] && (i < N_RAND - 1),
                      (i < N_RAND - 1) ? rnd_b[(i + 1) % N_RAND] : 8'h00);
        end

        // Reset during EN_HI, from line 1.
        send_byte(8'h0A, 1'b0, 8'h00);
        if (m_line == 0) send_byte(8'h0A, 1'b0, 8'h00);
        DATA_I = 8'h41;
        VLD_I  = 1'b1;
        @(negedge CLK_I);
        VLD_I = 1'b0;
        guard = 0;
        while (LCD_EN_O !== 1'b1 && guard < 20) begin
            @(negedge CLK_I);
            guard++;
        end
        check_val("mid_en_seen", LCD_EN_O, 1);
        RST_I = 1'b1;
        #1;
        check_val("mid_rst_en_async", LCD_EN_O, 0);
        check_val("mid_rst_rdy", RDY_O, 0);
        check_val("mid_rst_busy", BUSY_O, 1);
        m_col  = 0;
        m_line = 0;
        repeat (3) @(negedge CLK_I);
        RST_I = 1'b0;
        check_init();
        send_byte(8'h0D, 1'b0, 8'h00);
        check_val("post_rst_line0", last_data0, 8'h80);
        send_byte(8'h42, 1'b0, 8'h00);

        // No stray strobes once the input goes quiet.
        rises   = 0;
        prev_en = LCD_EN_O;
        repeat (30) begin
            @(negedge CLK_I);
            if (LCD_EN_O === 1'b1 && !prev_en) rises++;
            prev_en = LCD_EN_O;
        end
        check_val("quiet_no_pulses", rises, 0);
        check_val("quiet_rdy", RDY_O, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
